// File: rtl/frame_relay_tile.sv
// rtl/frame_relay_tile.sv - frame data/strobe relay tile with local config frame capture
// Relays the frame chain through PIPE_STAGES registers and captures this tile's own frames.
module frame_relay_tile #(
  parameter int MaxFramesPerCol = 32,
  parameter int FrameBitsPerRow = 32,
  parameter int PIPE_STAGES     = 1,
  parameter int LOCAL_FRAMES    = 2,
  parameter int FRAME_BASE      = 0,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                                    UserCLK,
  input  logic                                    resetn,
  output logic                                    UserCLK_o,
  input  logic [FrameBitsPerRow-1:0]              FrameData,
  output logic [FrameBitsPerRow-1:0]              FrameData_o,
  input  logic [MaxFramesPerCol-1:0]              FrameStrobe,
  output logic [MaxFramesPerCol-1:0]              FrameStrobe_o,
  output logic [LOCAL_FRAMES*FrameBitsPerRow-1:0] ConfigBits,
  output logic                                    ConfigValid,
  output logic [COUNT_WIDTH-1:0]                  WriteCount
);

  logic [LOCAL_FRAMES-1:0] local_strobe;
  logic [LOCAL_FRAMES-1:0] written;
  logic [LOCAL_FRAMES-1:0] written_next;

  assign UserCLK_o = UserCLK;

  generate
    if (PIPE_STAGES == 0) begin : g_pass
      assign FrameData_o   = FrameData;
      assign FrameStrobe_o = FrameStrobe;
    end else begin : g_pipe
      logic [FrameBitsPerRow-1:0] data_pipe   [PIPE_STAGES];
      logic [MaxFramesPerCol-1:0] strobe_pipe [PIPE_STAGES];

      // Reset to zero so no stale strobe leaks downstream after reset.
      always_ff @(posedge UserCLK) begin
        if (!resetn) begin
          for (int s = 0; s < PIPE_STAGES; s++) begin
            data_pipe[s]   <= '0;
            strobe_pipe[s] <= '0;
          end
        end else begin
          data_pipe[0]   <= FrameData;
          strobe_pipe[0] <= FrameStrobe;
          for (int s = 1; s < PIPE_STAGES; s++) begin
            data_pipe[s]   <= data_pipe[s-1];
            strobe_pipe[s] <= strobe_pipe[s-1];
          end
        end
      end

      assign FrameData_o   = data_pipe[PIPE_STAGES-1];
      assign FrameStrobe_o = strobe_pipe[PIPE_STAGES-1];
    end
  endgenerate

  assign local_strobe = FrameStrobe[FRAME_BASE +: LOCAL_FRAMES];
  assign written_next = written | local_strobe;

  always_ff @(posedge UserCLK) begin
    if (!resetn) begin
      ConfigBits  <= '0;
      written     <= '0;
      ConfigValid <= 1'b0;
      WriteCount  <= '0;
    end else begin
      for (int i = 0; i < LOCAL_FRAMES; i++) begin
        if (local_strobe[i]) begin
          ConfigBits[i*FrameBitsPerRow +: FrameBitsPerRow] <= FrameData;
        end
      end
      written <= written_next;
      if (&written_next) begin
        ConfigValid <= 1'b1;
      end
      // One count per cycle with any local strobe, held at all-ones.
      if ((|local_strobe) && (WriteCount != {COUNT_WIDTH{1'b1}})) begin
        WriteCount <= WriteCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_frame_relay_tile.sv
// tb/tb_frame_relay_tile.sv - directed self-checking bench for frame_relay_tile
module tb_frame_relay_tile;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] frame_data;
  logic [31:0] frame_strobe;

  logic        clk_o;
  logic [31:0] data_o;
  logic [31:0] strobe_o;
  logic [63:0] config_bits;
  logic        config_valid;
  logic [3:0]  write_count;

  logic        clk_o0;
  logic [31:0] data_o0;
  logic [31:0] strobe_o0;
  logic [63:0] config_bits0;
  logic        config_valid0;
  logic [3:0]  write_count0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  frame_relay_tile #(
    .MaxFramesPerCol(32), .FrameBitsPerRow(32), .PIPE_STAGES(2),
    .LOCAL_FRAMES(2), .FRAME_BASE(4), .COUNT_WIDTH(4)
  ) dut (
    .UserCLK(clk), .resetn(resetn), .UserCLK_o(clk_o),
    .FrameData(frame_data), .FrameData_o(data_o),
    .FrameStrobe(frame_strobe), .FrameStrobe_o(strobe_o),
    .ConfigBits(config_bits), .ConfigValid(config_valid), .WriteCount(write_count)
  );

  frame_relay_tile #(
    .MaxFramesPerCol(32), .FrameBitsPerRow(32), .PIPE_STAGES(0),
    .LOCAL_FRAMES(2), .FRAME_BASE(4), .COUNT_WIDTH(4)
  ) dut0 (
    .UserCLK(clk), .resetn(resetn), .UserCLK_o(clk_o0),
    .FrameData(frame_data), .FrameData_o(data_o0),
    .FrameStrobe(frame_strobe), .FrameStrobe_o(strobe_o0),
    .ConfigBits(config_bits0), .ConfigValid(config_valid0), .WriteCount(write_count0)
  );

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [31:0] s);
    frame_data   = d;
    frame_strobe = s;
  endtask

  initial begin
    resetn = 1'b0;
    drive(32'h0, 32'h0);
    repeat (3) step();
    resetn = 1'b1;
    step();
    check("reset_data_o", data_o, 64'h0);
    check("reset_strobe_o", strobe_o, 64'h0);
    check("reset_config", config_bits, 64'h0);
    check("reset_valid", config_valid, 64'h0);
    check("reset_count", write_count, 64'h0);
    check("clk_o_high", clk_o, 64'h1);
    @(negedge clk);
    #1;
    check("clk_o_low", clk_o, 64'h0);

    // Relay latency: PIPE_STAGES=2 instance and combinational instance.
    step();
    drive(32'hA5A5A5A5, 32'h0000_0004);
    #1;
    check("comb_data_same_cycle", data_o0, 64'hA5A5A5A5);
    check("comb_strobe_same_cycle", strobe_o0, 64'h4);
    check("pipe_data_before", data_o, 64'h0);
    step();
    drive(32'h0, 32'h0);
    #1;
    check("comb_data_cleared", data_o0, 64'h0);
    check("pipe_data_edge1", data_o, 64'h0);
    check("pipe_strobe_edge1", strobe_o, 64'h0);
    step();
    check("pipe_data_edge2", data_o, 64'hA5A5A5A5);
    check("pipe_strobe_edge2", strobe_o, 64'h4);
    step();
    check("pipe_data_edge3", data_o, 64'h0);
    check("pipe_strobe_edge3", strobe_o, 64'h0);
    check("nonlocal_count", write_count, 64'h0);

    // Local capture.
    drive(32'h11111111, 32'h0000_0010);
    step();
    drive(32'h0, 32'h0);
    check("cap0_config", config_bits, 64'h00000000_11111111);
    check("cap0_valid", config_valid, 64'h0);
    check("cap0_count", write_count, 64'h1);
    drive(32'h22222222, 32'h0000_0020);
    step();
    drive(32'h0, 32'h0);
    check("cap1_config", config_bits, 64'h22222222_11111111);
    check("cap1_valid", config_valid, 64'h1);
    check("cap1_count", write_count, 64'h2);
    drive(32'h33333333, 32'h0000_0048);
    step();
    drive(32'h0, 32'h0);
    check("outside_config", config_bits, 64'h22222222_11111111);
    check("outside_valid", config_valid, 64'h1);
    check("outside_count", write_count, 64'h2);
    check("relay_local_strobe", strobe_o, 64'h20);
    check("relay_local_data", data_o, 64'h22222222);

    // Both local strobes together.
    drive(32'hDEADBEEF, 32'h0000_0030);
    step();
    drive(32'h0, 32'h0);
    check("dual_config", config_bits, 64'hDEADBEEF_DEADBEEF);
    check("dual_valid", config_valid, 64'h1);
    check("dual_count", write_count, 64'h3);
    check("comb_inst_count", write_count0, 64'h3);

    // Saturation of the 4-bit counter.
    drive(32'h0, 32'h0000_0010);
    repeat (20) step();
    drive(32'h0, 32'h0);
    check("sat_count", write_count, 64'hF);
    check("sat_config", config_bits, 64'hDEADBEEF_00000000);
    step();
    check("sat_hold", write_count, 64'hF);

    // Reset mid-operation.
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    drive(32'h44444444, 32'h0000_0010);
    step();
    check("pre_reset_frame0", config_bits, 64'h00000000_44444444);
    resetn = 1'b0;
    drive(32'h55555555, 32'h0000_0020);
    step();
    check("midreset_config", config_bits, 64'h0);
    check("midreset_valid", config_valid, 64'h0);
    check("midreset_count", write_count, 64'h0);
    check("midreset_strobe_o", strobe_o, 64'h0);
    resetn = 1'b1;
    drive(32'h0, 32'h0);
    step();
    drive(32'h66666666, 32'h0000_0020);
    step();
    drive(32'h0, 32'h0);
    check("post_reset_config", config_bits, 64'h66666666_00000000);
    check("post_reset_valid", config_valid, 64'h0);
    check("post_reset_count", write_count, 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
